display_responder: RTL

DISPLAY_RESPONDER -- requirements
Module: display_responder

---
 rtl/lc3_io_pkg.sv | 9 +
 rtl/baud_tick.sv | 28 ++
 rtl/display_responder.sv | 104 ++++++++++
 3 files changed

// File: rtl/lc3_io_pkg.sv
// Status codes exchanged with the LC-3 host through its device status registers.
// Shared by the display-side and keyboard-side responders.
package lc3_io_pkg;

   localparam logic [15:0] ST_IDLE = 16'h0000;
   localparam logic [15:0] ST_WAIT = 16'h0001;
   localparam logic [15:0] ST_DONE = 16'h0002;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// A synchronous clear parks the count at zero.
module baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 217
) (
   input  logic clk,
   input  logic clear,
   output logic tick
);

   localparam int unsigned W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/display_responder.sv
// LC-3 display device: sends the host's DDR character as one 8N1 UART frame
// when DSR reads "awaiting output", then reports completion back through DSR.
module display_responder #(
   parameter int unsigned CLKS_PER_BIT = 217
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic [15:0] DSR_OUT,
   input  logic [15:0] DDR_OUT,
   output logic [15:0] OUTPUT_DSR,
   output logic        o_Tx,
   output logic        o_Busy
);

   import lc3_io_pkg::*;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] data_q;
   logic [2:0] bit_idx;
   logic       tick;
   logic       baud_clear;
   logic       unused_ddr_hi;

   assign unused_ddr_hi = ^DDR_OUT[15:8];

   // The timer only runs while a frame is on the wire; reset clears it too.
   assign baud_clear = !i_Rst_n || (state == S_IDLE) || (state == S_DONE);

   baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk  (i_Clk),
      .clear(baud_clear),
      .tick (tick)
   );

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state   <= S_IDLE;
         data_q  <= '0;
         bit_idx <= '0;
      end else begin
         state <= next_state;
         if (state == S_IDLE && next_state == S_START) begin
            data_q <= DDR_OUT[7:0];
         end
         // Index wraps 7 -> 0 on the last data bit, so it is ready for the next frame.
         if (state == S_DATA && tick) begin
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   always_comb begin
      next_state = state;
      o_Tx       = 1'b1;
      OUTPUT_DSR = ST_IDLE;
      o_Busy     = 1'b1;
      case (state)
         S_IDLE: begin
            o_Busy = 1'b0;
            if (DSR_OUT == ST_WAIT) begin
               next_state = S_START;
            end
         end
         S_START: begin
            o_Tx = 1'b0;
            if (tick) begin
               next_state = S_DATA;
            end
         end
         S_DATA: begin
            o_Tx = data_q[bit_idx];
            if (tick && bit_idx == 3'd7) begin
               next_state = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               next_state = S_DONE;
            end
         end
         S_DONE: begin
            OUTPUT_DSR = ST_DONE;
            if (DSR_OUT != ST_WAIT) begin
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

endmodule
